// File: rtl/player_anim_sequencer_if.sv
// ---------------------------------------------------------------------------
// player_anim_sequencer_if
//   Bundles the control, raster and sprite-ROM-facing signals of the player
//   animation sequencer. Clock and reset stay as plain module ports.
//
//   Parameters
//     ADDR_W : spriteAddress width
//     FI_W   : frameIdx width ($clog2(NUM_FRAMES), minimum 1)
//
//   Signals (direction as seen by the sequencer, i.e. the slave modport)
//     start           in   1-cycle pulse, restart the sequence at frame 0
//     clear           in   1-cycle pulse, stop and hide the sprite
//     frameTick       in   1-cycle pulse, once per video frame
//     playerDirection in   0 = right, 1 = left, sampled on start
//     DrawX, DrawY    in   current raster position
//     PlayerX, PlayerY in  sprite top-left
//     playerOn        out  registered pixel-in-sprite flag
//     spriteAddress   out  registered sprite ROM address
//     frameIdx        out  current frame number
//     animDone        out  high while a one-shot sequence is parked on its
//                          last frame
// ---------------------------------------------------------------------------
interface player_anim_sequencer_if #(
  parameter int ADDR_W = 21,
  parameter int FI_W   = 2
);
  logic              start;
  logic              clear;
  logic              frameTick;
  logic              playerDirection;
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic [9:0]        PlayerX;
  logic [9:0]        PlayerY;
  logic              playerOn;
  logic [ADDR_W-1:0] spriteAddress;
  logic [FI_W-1:0]   frameIdx;
  logic              animDone;

  // Player state logic side: drives control and raster, consumes results.
  modport master (
    output start, clear, frameTick, playerDirection,
    output DrawX, DrawY, PlayerX, PlayerY,
    input  playerOn, spriteAddress, frameIdx, animDone
  );

  // Sequencer side.
  modport slave (
    input  start, clear, frameTick, playerDirection,
    input  DrawX, DrawY, PlayerX, PlayerY,
    output playerOn, spriteAddress, frameIdx, animDone
  );
endinterface

// File: rtl/player_anim_sequencer.sv
// ---------------------------------------------------------------------------
// player_anim_sequencer
//   Plays a multi-frame player sprite animation (death / jump / run) as a
//   counted sequence paced by a once-per-video-frame tick, and produces the
//   per-pixel playerOn / spriteAddress pair for the sprite ROM.
//
//   Ports
//     frame_Clk : pixel-rate clock
//     Reset     : asynchronous, active-high reset
//     bus       : player_anim_sequencer_if.slave (control, raster, outputs)
//
//   Parameters
//     PLAYER_WIDTH/PLAYER_HEIGHT : sprite size in pixels
//     NUM_FRAMES                 : frames in the sequence (>=1)
//     HOLD_TICKS                 : frameTicks each frame is shown (>=1)
//     LOOP                       : 0 = stop on last frame, 1 = wrap
//     ADDR_W                     : spriteAddress width
//     BASE_OFFSET                : ROM address of frame 0, right-facing
//     LEFT_OFFSET                : added for the left-facing sprite set
//
//   Optional build macro
//     ANIM_BLINK_EN : when defined, the DONE pose blinks (4 ticks visible,
//                     4 hidden) and returns to IDLE after 32 ticks in DONE.
//                     When undefined, DONE holds the last frame until
//                     clear/start.
//
//   Output latency is one cycle: playerOn/spriteAddress for raster (X,Y)
//   appear the cycle after DrawX/DrawY = (X,Y).
// ---------------------------------------------------------------------------
module player_anim_sequencer #(
  parameter int PLAYER_WIDTH  = 68,
  parameter int PLAYER_HEIGHT = 22,
  parameter int NUM_FRAMES    = 4,
  parameter int HOLD_TICKS    = 8,
  parameter int LOOP          = 0,
  parameter int ADDR_W        = 21,
  parameter int BASE_OFFSET   = 0,
  parameter int LEFT_OFFSET   = NUM_FRAMES * PLAYER_WIDTH * PLAYER_HEIGHT
) (
  input  logic                    frame_Clk,
  input  logic                    Reset,
  player_anim_sequencer_if.slave  bus
);

  localparam int FI_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int HC_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  localparam logic [FI_W-1:0] FRAME_LAST = FI_W'(NUM_FRAMES - 1);
  localparam logic [HC_W-1:0] HOLD_LAST  = HC_W'(HOLD_TICKS - 1);
  localparam logic [31:0]     FRAME_SZ   = 32'(PLAYER_WIDTH * PLAYER_HEIGHT);
  localparam logic [31:0]     WIDTH32    = 32'(PLAYER_WIDTH);
  localparam logic [10:0]     BOX_W_M1   = 11'(PLAYER_WIDTH - 1);
  localparam logic [10:0]     BOX_H_M1   = 11'(PLAYER_HEIGHT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // -------------------------------------------------------------------------
  // Sequencer state
  // -------------------------------------------------------------------------
  logic [1:0]        state,     state_n;
  logic [FI_W-1:0]   frame_idx, frame_n;
  logic [HC_W-1:0]   hold_cnt,  hold_n;
  logic              dir_latch, dir_n;
  logic              blink_vis;

`ifdef ANIM_BLINK_EN
  // Counts ticks spent in DONE; bit 2 selects the hidden half of each
  // 8-tick blink period, and the 32nd tick retires the sprite.
  logic [4:0]        blink_cnt, blink_n;
`endif

  always_comb begin
    state_n = state;
    frame_n = frame_idx;
    hold_n  = hold_cnt;
    dir_n   = dir_latch;
`ifdef ANIM_BLINK_EN
    blink_n = blink_cnt;
`endif
    if (bus.clear) begin
      // clear beats start when both arrive together
      state_n = S_IDLE;
      frame_n = '0;
      hold_n  = '0;
    end else if (bus.start) begin
      // restart from any state; a coincident tick is swallowed here
      state_n = S_PLAY;
      frame_n = '0;
      hold_n  = '0;
      dir_n   = bus.playerDirection;
    end else if (bus.frameTick) begin
      case (state)
        S_PLAY: begin
          if (hold_cnt != HOLD_LAST) begin
            hold_n = hold_cnt + 1'b1;
          end else begin
            hold_n = '0;
            if (frame_idx != FRAME_LAST)
              frame_n = frame_idx + 1'b1;
            else if (LOOP != 0)
              frame_n = '0;
            else
              state_n = S_DONE;   // frame index parks on the last frame
          end
        end
`ifdef ANIM_BLINK_EN
        S_DONE: begin
          if (blink_cnt == 5'd31)
            state_n = S_IDLE;
          else
            blink_n = blink_cnt + 5'd1;
        end
`endif
        default: ;
      endcase
    end
`ifdef ANIM_BLINK_EN
    // every fresh entry to DONE starts the blink pattern in its visible half
    if (state_n == S_DONE && state != S_DONE)
      blink_n = '0;
`endif
  end

`ifdef ANIM_BLINK_EN
  assign blink_vis = (state != S_DONE) || !blink_cnt[2];
`else
  assign blink_vis = 1'b1;
`endif

  // -------------------------------------------------------------------------
  // Hit box. Widened to 11 bits so PlayerX+PLAYER_WIDTH-1 near the right
  // edge of the 10-bit raster does not wrap and falsely reject pixels.
  // -------------------------------------------------------------------------
  logic [10:0] dx, dy, px, py;
  logic        in_box;
  logic        active;

  assign dx = {1'b0, bus.DrawX};
  assign dy = {1'b0, bus.DrawY};
  assign px = {1'b0, bus.PlayerX};
  assign py = {1'b0, bus.PlayerY};

  assign in_box = (dx >= px) && (dx <= px + BOX_W_M1) &&
                  (dy >= py) && (dy <= py + BOX_H_M1);
  assign active = (state != S_IDLE);

  // Address in 32 bits, truncated to the ROM width. The row/column offsets
  // are only meaningful inside the box, which is the only time they are
  // captured.
  logic [ADDR_W-1:0] addr_nx;

  assign addr_nx = ADDR_W'(32'(BASE_OFFSET)
                         + (dir_latch ? 32'(LEFT_OFFSET) : 32'd0)
                         + 32'(frame_idx) * FRAME_SZ
                         + 32'(dy - py) * WIDTH32
                         + 32'(dx - px));

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  logic              player_on;
  logic [ADDR_W-1:0] sprite_addr;

  always_ff @(posedge frame_Clk or posedge Reset) begin
    if (Reset) begin
      state       <= S_IDLE;
      frame_idx   <= '0;
      hold_cnt    <= '0;
      dir_latch   <= 1'b0;
      player_on   <= 1'b0;
      sprite_addr <= '0;
`ifdef ANIM_BLINK_EN
      blink_cnt   <= '0;
`endif
    end else begin
      state       <= state_n;
      frame_idx   <= frame_n;
      hold_cnt    <= hold_n;
      dir_latch   <= dir_n;
`ifdef ANIM_BLINK_EN
      blink_cnt   <= blink_n;
`endif
      // pixel outputs use the sequencer state of the sample cycle, so a
      // frame change mid-raster lands on the very next pixel
      player_on   <= in_box && active && blink_vis;
      if (in_box && active)
        sprite_addr <= addr_nx;
    end
  end

  assign bus.playerOn      = player_on;
  assign bus.spriteAddress = sprite_addr;
  assign bus.frameIdx      = frame_idx;
  assign bus.animDone      = (state == S_DONE);

endmodule
